// File: rtl/hyperbus_pkg.sv
// hyperbus_pkg: shared state encoding, command-address field positions and constants
package hyperbus_pkg;
  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, RECOVER} state_t;
  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;
  localparam int CA_ROW_HI = 44;
  localparam int CA_ROW_LO = 16;
  localparam int CA_COL_HI = 2;
  localparam int CA_COL_LO = 0;
  localparam int ROW_W = CA_ROW_HI - CA_ROW_LO + 1;
  localparam logic [15:0] RD_TIMEOUT_DATA = 16'hFFFF;
endpackage

// File: rtl/hyperbus_ca_encode.sv
// hyperbus_ca_encode: word address + direction -> 48-bit HyperBus command-address
module hyperbus_ca_encode
  import hyperbus_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:1] wadr,
  input  logic          rd,
  output logic [47:0]   ca
);
  always_comb begin
    ca = '0;
    ca[CA_RW] = rd;
    ca[CA_AS] = 1'b0;
    ca[CA_BT] = 1'b1;
    ca[CA_ROW_HI:CA_ROW_LO] = ROW_W'(wadr[AW-1:4]);
    ca[CA_COL_HI:CA_COL_LO] = wadr[3:1];
  end
endmodule

// File: rtl/hyperbus_ctrl.sv
// hyperbus_ctrl: hbus single-word responder that sequences one HyperBus transaction per request
module hyperbus_ctrl
  import hyperbus_pkg::*;
#(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int LATENCY = 6,
  parameter bit FIXED_LATENCY = 1'b0,
  parameter int CS_HIGH_CYC = 2,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                       hbus_clk,
  input  logic                       hbus_rst,
  input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  input  logic [1:0]                 hbus_mask_i,
  input  logic                       hbus_rrq,
  input  logic                       hbus_wrq,
  output logic                       hbus_ready,
  output logic                       hbus_valid,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  output logic                       phy_cs_n,
  output logic                       phy_ck_en,
  output logic [15:0]                phy_dq_o,
  output logic                       phy_dq_oe,
  output logic [1:0]                 phy_rwds_o,
  output logic                       phy_rwds_oe,
  input  logic [1:0]                 phy_rwds_i,
  input  logic [15:0]                phy_dq_i,
  input  logic                       phy_rx_valid,
  output logic                       timeout_o
);
  localparam logic [15:0] CA_LAST = 16'd2;
  localparam logic [15:0] LAT1 = 16'(LATENCY - 1);
  localparam logic [15:0] LAT2 = 16'(2 * LATENCY - 1);
  localparam logic [15:0] RD_LAST = 16'(RD_TIMEOUT - 1);
  localparam logic [15:0] REC_W = 16'(CS_HIGH_CYC - 1);
  localparam logic [15:0] REC_R = 16'(CS_HIGH_CYC);
  state_t state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [HBUS_ADDR_WIDTH-1:1] adr_q, adr_n;
  logic [HBUS_DATA_WIDTH-1:0] dat_q, dat_o_d;
  logic [1:0] mask_q, rwds_o_d;
  logic rd_q, rd_n, lat2, take;
  logic [47:0] ca;
  logic [15:0] ca_word, dq_o_d;
  logic cs_n_d, dq_oe_d, rwds_oe_d, valid_d, timeout_d;
  logic unused_adr0;
  assign unused_adr0 = hbus_adr_i[0];
  hyperbus_ca_encode #(.AW(HBUS_ADDR_WIDTH)) u_ca (
    .wadr (adr_n),
    .rd   (rd_n),
    .ca   (ca)
  );
  always_ff @(posedge hbus_clk) begin
    if (hbus_rst) begin
      state <= RECOVER;
      cnt <= REC_R;
      adr_q <= '0;
      dat_q <= '0;
      mask_q <= '0;
      rd_q <= 1'b0;
      lat2 <= 1'b0;
      phy_cs_n <= 1'b1;
      phy_ck_en <= 1'b0;
      phy_dq_oe <= 1'b0;
      phy_rwds_oe <= 1'b0;
      phy_dq_o <= '0;
      phy_rwds_o <= '0;
      hbus_ready <= 1'b0;
      hbus_valid <= 1'b0;
      hbus_dat_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      adr_q <= adr_n;
      rd_q <= rd_n;
      if (take) begin
        dat_q <= hbus_dat_i;
        mask_q <= hbus_mask_i;
      end
      if (state == CA && cnt == 16'd1) lat2 <= (|phy_rwds_i) | FIXED_LATENCY;
      phy_cs_n <= cs_n_d;
      phy_ck_en <= ~cs_n_d;
      phy_dq_oe <= dq_oe_d;
      phy_rwds_oe <= rwds_oe_d;
      phy_dq_o <= dq_o_d;
      phy_rwds_o <= rwds_o_d;
      hbus_ready <= state_d == IDLE;
      hbus_valid <= valid_d;
      hbus_dat_o <= dat_o_d;
      timeout_o <= timeout_d;
    end
  end
  // reads keep one extra recovery clock that carries the hbus_valid strobe
  always_comb begin
    state_d = state;
    cnt_d = cnt + 16'd1;
    take = 1'b0;
    case (state)
      IDLE: begin
        take = hbus_wrq | hbus_rrq;
        cnt_d = '0;
        state_d = take ? CA : IDLE;
      end
      CA: if (cnt == CA_LAST) begin
        state_d = LAT;
        cnt_d = '0;
      end
      LAT: if (cnt == (lat2 ? LAT2 : LAT1)) begin
        state_d = rd_q ? RDATA : WDATA;
        cnt_d = '0;
      end
      WDATA: begin
        state_d = RECOVER;
        cnt_d = REC_W;
      end
      RDATA: if (phy_rx_valid || cnt == RD_LAST) begin
        state_d = RECOVER;
        cnt_d = REC_R;
      end
      RECOVER: begin
        cnt_d = cnt - 16'd1;
        state_d = cnt == '0 ? IDLE : RECOVER;
      end
      default: state_d = RECOVER;
    endcase
    adr_n = take ? hbus_adr_i[HBUS_ADDR_WIDTH-1:1] : adr_q;
    rd_n = take ? (hbus_rrq & ~hbus_wrq) : rd_q;
  end
  always_comb begin
    ca_word = cnt_d == 16'd0 ? ca[47:32] : cnt_d == 16'd1 ? ca[31:16] : ca[15:0];
    cs_n_d = state_d == IDLE || state_d == RECOVER;
    dq_oe_d = state_d == CA || state_d == WDATA;
    rwds_oe_d = state_d == WDATA;
    dq_o_d = state_d == CA ? ca_word : state_d == WDATA ? dat_q : 16'h0;
    rwds_o_d = state_d == WDATA ? mask_q : 2'b00;
    valid_d = state == RDATA && state_d == RECOVER;
    dat_o_d = valid_d ? (phy_rx_valid ? phy_dq_i : RD_TIMEOUT_DATA) : hbus_dat_o;
    timeout_d = timeout_o | (valid_d & ~phy_rx_valid);
  end
endmodule

// File: tb/tb_hyperbus_ctrl.sv
// tb_hyperbus_ctrl: cycle-timeline reference model of hyperbus_ctrl with directed and random transactions
module tb_hyperbus_ctrl;
  localparam int LAT = 6;
  localparam int C = 2;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] adr = '0;
  logic [15:0] dat = '0, dq_i = '0;
  logic [1:0] mask = '0, rwds_i = '0;
  logic rrq = 1'b0, wrq = 1'b0, f_rrq = 1'b0, f_wrq = 1'b0, rx_valid = 1'b0;
  logic a_ready, a_valid, a_cs_n, a_ck_en, a_dq_oe, a_rwds_oe, a_to;
  logic b_ready, b_valid, b_cs_n, b_ck_en, b_dq_oe, b_rwds_oe, b_to;
  logic [15:0] a_dat_o, a_dq_o, b_dat_o, b_dq_o;
  logic [1:0] a_rwds_o, b_rwds_o;
  int checks = 0, errors = 0;
  bit to_a = 1'b0, to_b = 1'b0;
  hyperbus_ctrl dut (
    .hbus_clk(clk), .hbus_rst(rst), .hbus_adr_i(adr), .hbus_dat_i(dat), .hbus_mask_i(mask),
    .hbus_rrq(rrq), .hbus_wrq(wrq), .hbus_ready(a_ready), .hbus_valid(a_valid), .hbus_dat_o(a_dat_o),
    .phy_cs_n(a_cs_n), .phy_ck_en(a_ck_en), .phy_dq_o(a_dq_o), .phy_dq_oe(a_dq_oe),
    .phy_rwds_o(a_rwds_o), .phy_rwds_oe(a_rwds_oe), .phy_rwds_i(rwds_i), .phy_dq_i(dq_i),
    .phy_rx_valid(rx_valid), .timeout_o(a_to)
  );
  hyperbus_ctrl #(.FIXED_LATENCY(1'b1)) dut_f (
    .hbus_clk(clk), .hbus_rst(rst), .hbus_adr_i(adr), .hbus_dat_i(dat), .hbus_mask_i(mask),
    .hbus_rrq(f_rrq), .hbus_wrq(f_wrq), .hbus_ready(b_ready), .hbus_valid(b_valid), .hbus_dat_o(b_dat_o),
    .phy_cs_n(b_cs_n), .phy_ck_en(b_ck_en), .phy_dq_o(b_dq_o), .phy_dq_oe(b_dq_oe),
    .phy_rwds_o(b_rwds_o), .phy_rwds_oe(b_rwds_oe), .phy_rwds_i(rwds_i), .phy_dq_i(dq_i),
    .phy_rx_valid(rx_valid), .timeout_o(b_to)
  );
  initial begin
    #2000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [24:0] obs(input bit s);
    return s ? {b_cs_n, b_ck_en, b_dq_oe, b_rwds_oe, b_ready, b_valid, b_to, b_rwds_o, b_dq_o}
             : {a_cs_n, a_ck_en, a_dq_oe, a_rwds_oe, a_ready, a_valid, a_to, a_rwds_o, a_dq_o};
  endfunction
  function automatic logic [47:0] ca_of(input bit rd, input logic [31:0] a);
    return {rd, 1'b0, 1'b1, 1'b0, a[31:4], 13'd0, a[3:1]};
  endfunction
  task automatic chk(input string tag, input logic [47:0] o, input logic [47:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // walks one transaction cycle by cycle; k is the cycle index with the request accepted at the end of T0
  task automatic run(input bit s, input bit rd, input logic [31:0] a, input logic [15:0] d16,
                     input logic [1:0] m, input logic [1:0] rw, input int d, input bit both, input bit spam);
    int n, tn, busy, e, gap;
    logic [47:0] ca;
    logic [15:0] rdat, edq;
    logic [24:0] ex, o;
    bit wr, cs, hit, tos;
    wr = !rd;
    n = (rw != 2'b00 || s) ? 2 * LAT : LAT;
    tn = d >= 0 ? 4 + n + d : 3 + n + TO;
    busy = wr ? 4 + n : tn;
    e = wr ? busy + 1 + C : tn + 2 + C;
    ca = ca_of(rd, a);
    rdat = 16'($urandom);
    gap = 0;
    for (int k = 0; k <= e; k++) begin
      if (k > 0) tick();
      adr = k == 0 ? a : $urandom;
      dat = k == 0 ? d16 : 16'($urandom);
      mask = k == 0 ? m : 2'($urandom);
      {rrq, wrq, f_rrq, f_wrq} = '0;
      if (k == 0) begin
        if (s) {f_rrq, f_wrq} = {rd | both, wr};
        else {rrq, wrq} = {rd | both, wr};
      end else if (spam && k < e) begin
        if (s) f_rrq = 1'b1;
        else rrq = 1'b1;
      end
      rwds_i = k == 2 ? rw : 2'($urandom);
      hit = rd && d >= 0 && k == tn;
      rx_valid = hit || k == 4 || k > busy;
      dq_i = hit ? rdat : 16'($urandom);
      if (rd && d < 0 && k == tn + 1) begin
        if (s) to_b = 1'b1;
        else to_a = 1'b1;
      end
      tos = s ? to_b : to_a;
      cs = k == 0 || k > busy;
      edq = (k >= 1 && k <= 3) ? ca[(3 - k) * 16 +: 16] : (wr && k == busy) ? d16 : 16'h0;
      ex = {cs, !cs, (k >= 1 && k <= 3) || (wr && k == busy), wr && k == busy, k == 0 || k == e,
            rd && k == tn + 1, tos, (wr && k == busy) ? m : 2'b00, edq};
      o = obs(s);
      chk($sformatf("%s%0d_k%0d", rd ? "rd" : "wr", s, k), 48'(o), 48'(ex));
      if (rd && k == tn + 1)
        chk("rdata", 48'(s ? b_dat_o : a_dat_o), 48'(d >= 0 ? rdat : 16'hFFFF));
      if (k > busy && k < e && o[24] && !o[20]) gap++;
    end
    if (wr) chk("cs_gap", 48'(gap), 48'(C));
  endtask
  task automatic idle(input int n);
    logic [24:0] o;
    {rrq, wrq, f_rrq, f_wrq, rx_valid} = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      o = obs(1'b0);
      chk("idle_hold", 48'({o[24], o[20], o[19]}), 48'(3'b110));
    end
  endtask
  initial begin
    logic [24:0] o;
    int n;
    repeat (3) tick();
    o = obs(1'b0);
    chk("rst_state", 48'(o), 48'({1'b1, 24'h0}));
    chk("rst_dat0", 48'(a_dat_o), 48'h0);
    rst = 1'b0;
    n = 0;
    while (n < 20 && !a_ready) begin tick(); n++; end
    chk("rst_release", 48'(n), 48'(C + 1));
    run(1'b0, 1'b0, 32'h0000_1234, 16'hBEEF, 2'b01, 2'b00, 0, 1'b0, 1'b0);
    run(1'b0, 1'b1, 32'h0000_1234, 16'h0000, 2'b00, 2'b11, 1, 1'b0, 1'b0);
    run(1'b0, 1'b1, $urandom, 16'h0000, 2'b00, 2'b00, -1, 1'b0, 1'b0);
    run(1'b0, 1'b0, $urandom, 16'($urandom), 2'($urandom), 2'b00, 0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 32'h00AB_CDEF, 16'h1357, 2'b10, 2'b01, 0, 1'b1, 1'b1);
    idle(3);
    for (int i = 0; i < 10; i++)
      run(1'($urandom), 1'($urandom), $urandom, 16'($urandom), 2'($urandom), 2'($urandom),
          int'($urandom_range(0, 5)), 1'b0, 1'b0);
    adr = 32'h0000_5678;
    rrq = 1'b1;
    tick();
    rrq = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    to_a = 1'b0;
    to_b = 1'b0;
    o = obs(1'b0);
    chk("rst_abort", 48'(o), 48'({1'b1, 24'h0}));
    chk("rst_abort_dat", 48'(a_dat_o), 48'h0);
    rst = 1'b0;
    rx_valid = 1'b1;
    n = 0;
    while (n < 20 && !a_ready) begin
      tick();
      n++;
      chk("rst_novalid", 48'(a_valid), 48'h0);
    end
    chk("rst_recover", 48'(n), 48'(C + 1));
    rx_valid = 1'b0;
    run(1'b1, 1'b0, $urandom, 16'($urandom), 2'($urandom), 2'b00, 0, 1'b0, 1'b0);
    run(1'b1, 1'b0, $urandom, 16'($urandom), 2'($urandom), 2'b00, 0, 1'b0, 1'b0);
    run(1'b1, 1'b1, $urandom, 16'h0000, 2'b00, 2'b00, 2, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
